// File: rtl/spi_flash_rd_seq_if.sv
// ----------------------------------------------------------------------------
// spi_flash_rd_seq_if
// Bus bundle for spi_flash_rd_seq: the Wishbone master port toward the SPI
// controller plus the valid/ready byte stream toward the consumer.
//
// Signals (direction seen from the sequencer, modport master):
//   wb_adr_o  out 32  Wishbone address
//   wb_dat_o  out 32  Wishbone write data
//   wb_dat_i  in  32  Wishbone read data
//   wb_sel_o  out 4   byte selects (always all ones)
//   wb_cyc_o  out 1   Wishbone cycle
//   wb_stb_o  out 1   Wishbone strobe
//   wb_we_o   out 1   Wishbone write enable
//   wb_ack_i  in  1   Wishbone acknowledge
//   m_data    out 8   stream byte
//   m_valid   out 1   stream valid
//   m_ready   in  1   stream ready
// Modport slave is the mirror image (controller + stream consumer side).
// ----------------------------------------------------------------------------
interface spi_flash_rd_seq_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_dat_i, wb_ack_i,
        output m_data, m_valid,
        input  m_ready
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_dat_i, wb_ack_i,
        input  m_data, m_valid,
        output m_ready
    );
endinterface

// File: rtl/spi_flash_rd_seq.sv
// ----------------------------------------------------------------------------
// spi_flash_rd_seq
// Wishbone master that drives the SPI controller register map to perform a
// serial-flash READ (command, 24-bit address, one dummy byte per data byte)
// and returns the received data bytes on a valid/ready stream.
//
// Ports:
//   clk      in  1    clock
//   rst_i    in  1    asynchronous active-high reset
//   start    in  1    request pulse, sampled only when idle
//   addr     in  24   flash byte address (captured on start)
//   len      in  LW   data byte count (captured on start, 0 = no-op)
//   clk_div  in  CDW  SPI divider written to CFG[CDW+1:2]
//   busy_o   out 1    transfer in progress
//   done_o   out 1    one-cycle completion pulse
//   bus      master   Wishbone master + byte stream (spi_flash_rd_seq_if)
//
// Build option: define SPI_FLASH_RD_FAST_EN to issue FAST READ (0x0B) with one
// extra dummy byte after the address (5-byte header instead of 4).
// ----------------------------------------------------------------------------
module spi_flash_rd_seq #(
    parameter int LW  = 16,
    parameter int CDW = 8
) (
    input  logic           clk,
    input  logic           rst_i,
    input  logic           start,
    input  logic [23:0]    addr,
    input  logic [LW-1:0]  len,
    input  logic [CDW-1:0] clk_div,
    output logic           busy_o,
    output logic           done_o,
    spi_flash_rd_seq_if.master bus
);

`ifdef SPI_FLASH_RD_FAST_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam logic [2:0] HDR = 3'd5;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam logic [2:0] HDR = 3'd4;
`endif

    localparam logic [15:0] OFF_RXDATA = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_CFG    = 16'h0008;
    localparam logic [15:0] OFF_CTRL   = 16'h000C;
    localparam logic [15:0] OFF_LEVEL  = 16'hFE00;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_FLUSH, S_EN, S_TX, S_POLL, S_RX, S_OUT, S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [15:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic [2:0]     idx_q, idx_d;
    logic [LW-1:0]  rem_q, rem_d;
    logic [23:0]    addr_q, addr_d;
    logic [CDW-1:0] div_q, div_d;
    logic [7:0]     mdata_q, mdata_d;
    logic           mvalid_q, mvalid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           acc_req;
    logic           acc_we;
    logic [15:0]    acc_adr;
    logic [31:0]    acc_dat;
    logic           wb_ack;
    logic [7:0]     tx_byte;
    logic [31:0]    cfg_word;

    assign wb_ack = cyc_q & bus.wb_ack_i;

    always_comb begin
        cfg_word = '0;
        cfg_word[CDW+1:2] = div_q;
    end

    // Header bytes by index; indices past the address (including the FAST
    // READ dummy slot) send 0x00.
    always_comb begin
        case (idx_q)
            3'd0:    tx_byte = CMD;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        div_d    = div_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_req  = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = '0;
        acc_dat  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = addr;
                    rem_d  = len;
                    div_d  = clk_div;
                    idx_d  = '0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = OFF_CFG; acc_dat = cfg_word;
                if (wb_ack) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = OFF_CTRL; acc_dat = 32'h7;
                if (wb_ack) state_d = S_EN;
            end
            S_EN: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = OFF_CTRL; acc_dat = 32'h1;
                if (wb_ack) state_d = S_TX;
            end
            S_TX: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = OFF_TXDATA; acc_dat = {24'h0, tx_byte};
                if (wb_ack) state_d = S_POLL;
            end
            S_POLL: begin
                acc_req = 1'b1; acc_adr = OFF_LEVEL;
                if (wb_ack && bus.wb_dat_i != '0) state_d = S_RX;
            end
            S_RX: begin
                acc_req = 1'b1; acc_adr = OFF_RXDATA;
                if (wb_ack) begin
                    if (idx_q < HDR) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_TX;
                    end else begin
                        mdata_d  = bus.wb_dat_i[7:0];
                        mvalid_d = 1'b1;
                        state_d  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (mvalid_q && bus.m_ready) begin
                    mvalid_d = 1'b0;
                    rem_d    = rem_q - 1'b1;
                    state_d  = (rem_q == LW'(1)) ? S_FIN : S_TX;
                end
            end
            S_FIN: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = OFF_CTRL; acc_dat = 32'h0;
                if (wb_ack) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Launch only from a cycle with cyc low; dropping cyc on the ack
        // cycle therefore guarantees one idle cycle between accesses.
        if (wb_ack) begin
            cyc_d = 1'b0;
        end else if (acc_req && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            div_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            div_q    <= div_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.wb_adr_o = {16'h0000, adr_q};
    assign bus.wb_dat_o = dat_q;
    assign bus.wb_sel_o = 4'hF;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_we_o  = we_q;
    assign bus.m_data   = mdata_q;
    assign bus.m_valid  = mvalid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_rd_seq
// Scoreboard bench for spi_flash_rd_seq. Each request computes the full list
// of expected register writes and stream bytes from the read protocol rules;
// a Wishbone slave process and a stream sink process pop and compare as the
// DUT presents accesses and bytes. LW is reduced so the all-ones length is
// reachable in a short run.
// ----------------------------------------------------------------------------
module tb_spi_flash_rd_seq;
    localparam int LW  = 4;
    localparam int CDW = 8;
`ifdef SPI_FLASH_RD_FAST_EN
    localparam int         HDR = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic           clk;
    logic           rst_i;
    logic           start;
    logic [23:0]    addr;
    logic [LW-1:0]  len;
    logic [CDW-1:0] clk_div;
    logic           busy_o;
    logic           done_o;

    spi_flash_rd_seq_if bus();

    spi_flash_rd_seq #(.LW(LW), .CDW(CDW)) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .start   (start),
        .addr    (addr),
        .len     (len),
        .clk_div (clk_div),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_wr_q[$];
    logic [7:0]  exp_st_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  preset_rx_q[$];
    int          zplan_q[$];

    int lvl_reads  = 0;
    int rx_reads   = 0;
    int done_cnt   = 0;
    bit busy_seen  = 0;
    bit cyc_seen   = 0;
    bit stall_req  = 0;
    bit rand_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Wishbone slave: random ack latency, RX FIFO level plan, RX data queue.
    initial begin : slave
        bit          have_plan, lvl_ok, prev_cyc;
        int          wait_cnt, zeros_left;
        logic [63:0] held;
        logic        held_we;
        logic [23:0] junk;
        logic [7:0]  rb;
        have_plan = 0; lvl_ok = 0; prev_cyc = 0; wait_cnt = 0; zeros_left = 0;
        held = '0; held_we = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                bus.wb_ack_i = 1'b0;
                have_plan = 0; lvl_ok = 0; prev_cyc = 0; wait_cnt = 0;
            end else if (bus.wb_ack_i) begin
                chk("wb_gap", bus.wb_cyc_o, 1'b0);
                bus.wb_ack_i = 1'b0;
                bus.wb_dat_i = $urandom();
                prev_cyc = 0;
            end else if (bus.wb_cyc_o) begin
                if (prev_cyc) begin
                    chk("wb_hold", {bus.wb_adr_o, bus.wb_dat_o}, held);
                    chk("wb_hold_we", bus.wb_we_o, held_we);
                end else begin
                    held     = {bus.wb_adr_o, bus.wb_dat_o};
                    held_we  = bus.wb_we_o;
                    wait_cnt = $urandom_range(0, 2);
                    chk("wb_stb", bus.wb_stb_o, 1'b1);
                    chk("wb_sel", bus.wb_sel_o, 4'hF);
                end
                prev_cyc = 1;
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    bus.wb_dat_i = $urandom();
                end else begin
                    bus.wb_ack_i = 1'b1;
                    if (bus.wb_we_o) begin
                        if (bus.wb_adr_o == 32'h4) chk("tx_while_pending", bus.m_valid, 1'b0);
                        if (exp_wr_q.size() > 0) begin
                            chk("wr", {bus.wb_adr_o, bus.wb_dat_o}, exp_wr_q.pop_front());
                        end else begin
                            total++; bad++;
                            $display("FAIL wr_extra: got adr=%h dat=%h required none", bus.wb_adr_o, bus.wb_dat_o);
                        end
                    end else if (bus.wb_adr_o == 32'hFE00) begin
                        lvl_reads++;
                        if (!have_plan) begin
                            zeros_left = (zplan_q.size() > 0) ? zplan_q.pop_front() : 0;
                            have_plan = 1;
                        end
                        if (zeros_left > 0) begin
                            bus.wb_dat_i = '0;
                            zeros_left--;
                        end else begin
                            bus.wb_dat_i = 32'($urandom_range(1, 8));
                            have_plan = 0;
                            lvl_ok = 1;
                        end
                    end else if (bus.wb_adr_o == 32'h0) begin
                        rx_reads++;
                        chk("rx_after_level", lvl_ok, 1'b1);
                        lvl_ok = 0;
                        junk = 24'($urandom());
                        rb = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
                        bus.wb_dat_i = {junk, rb};
                    end else begin
                        total++; bad++;
                        $display("FAIL rd_adr: got %h required 0 or fe00", bus.wb_adr_o);
                    end
                end
            end else begin
                prev_cyc = 0;
                bus.wb_dat_i = $urandom();
            end
        end
    end

    // Stream sink and status monitor.
    initial begin : sink
        bit         prev_valid, prev_hs, r;
        logic [7:0] prev_data;
        int         stall_cnt;
        prev_valid = 0; prev_hs = 0; prev_data = '0; stall_cnt = 0; r = 0;
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                bus.m_ready = 1'b0;
                prev_valid = 0; prev_hs = 0; stall_cnt = 0;
            end else begin
                if (done_o) begin
                    done_cnt++;
                    chk("busy_at_done", busy_o, 1'b0);
                end
                if (busy_o) busy_seen = 1;
                if (bus.wb_cyc_o) cyc_seen = 1;
                if (prev_valid && !prev_hs) begin
                    chk("m_valid_hold", bus.m_valid, 1'b1);
                    chk("m_data_hold", bus.m_data, prev_data);
                end
                if (bus.m_valid && stall_req) begin
                    stall_req = 0;
                    stall_cnt = 10;
                end
                if (stall_cnt > 0) begin
                    r = 0;
                    stall_cnt--;
                end else if (rand_ready) begin
                    r = ($urandom_range(0, 2) != 0);
                end else begin
                    r = 1;
                end
                if (bus.m_valid && r) begin
                    if (exp_st_q.size() > 0) begin
                        chk("stream", bus.m_data, exp_st_q.pop_front());
                    end else begin
                        total++; bad++;
                        $display("FAIL stream_extra: got %h required none", bus.m_data);
                    end
                end
                prev_valid = bus.m_valid;
                prev_hs    = bus.m_valid && r;
                prev_data  = bus.m_data;
                bus.m_ready = r;
            end
        end
    end

    // Reference model: the whole transaction derived from the READ protocol.
    task automatic prep(input logic [23:0] a, input int n, input logic [CDW-1:0] d,
                        input int zfix, output int exp_lvl);
        logic [7:0] hb[5];
        logic [7:0] b;
        int z;
        hb[0] = CMD; hb[1] = a[23:16]; hb[2] = a[15:8]; hb[3] = a[7:0]; hb[4] = 8'h00;
        exp_lvl = 0;
        if (n > 0) begin
            exp_wr_q.push_back({32'h8, 32'(d) << 2});
            exp_wr_q.push_back({32'hC, 32'h7});
            exp_wr_q.push_back({32'hC, 32'h1});
            for (int i = 0; i < HDR + n; i++)
                exp_wr_q.push_back({32'h4, 24'h0, (i < HDR) ? hb[i] : 8'h00});
            exp_wr_q.push_back({32'hC, 32'h0});
            for (int i = 0; i < HDR + n; i++) begin
                b = (preset_rx_q.size() > 0) ? preset_rx_q.pop_front() : 8'($urandom());
                rx_q.push_back(b);
                if (i >= HDR) exp_st_q.push_back(b);
                z = (zfix >= 0) ? zfix : $urandom_range(0, 2);
                zplan_q.push_back(z);
                exp_lvl += z + 1;
            end
        end
        preset_rx_q.delete();
        lvl_reads = 0; rx_reads = 0; done_cnt = 0; busy_seen = 0; cyc_seen = 0;
    endtask

    task automatic clear_model();
        exp_wr_q.delete(); exp_st_q.delete(); rx_q.delete(); zplan_q.delete();
        stall_req = 0;
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [23:0] a, input int n, input logic [CDW-1:0] d);
        addr = a; len = LW'(n); clk_div = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_read(input logic [23:0] a, input int n, input logic [CDW-1:0] d,
                            input int zfix, input bit stall);
        int exp_lvl, cyc;
        prep(a, n, d, zfix, exp_lvl);
        stall_req = stall;
        pulse_start(a, n, d);
        if (n == 0) begin
            chk("len0_done", done_o, 1'b1);
            chk("len0_busy", busy_o, 1'b0);
        end else begin
            chk("busy_after_start", busy_o, 1'b1);
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("wr_left", exp_wr_q.size(), 0);
        chk("stream_left", exp_st_q.size(), 0);
        chk("rx_left", rx_q.size(), 0);
        chk("level_reads", lvl_reads, exp_lvl);
        chk("rx_reads", rx_reads, (n > 0) ? HDR + n : 0);
        if (n == 0) begin
            chk("len0_cyc_seen", cyc_seen, 1'b0);
            chk("len0_busy_seen", busy_seen, 1'b0);
        end
        if (done_cnt == 0) do_reset();
        clear_model();
    endtask

    // mode 0: reset while a later TXDATA access is on the bus;
    // mode 1: reset while a stream byte is pending.
    task automatic reset_mid(input int mode);
        int  exp_lvl, cyc;
        bit  hit;
        prep(24'h00ABCD, 3, 8'h03, -1, exp_lvl);
        pulse_start(24'h00ABCD, 3, 8'h03);
        hit = 0; cyc = 0;
        while (!hit && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mode == 0) hit = bus.wb_cyc_o && bus.wb_we_o && (bus.wb_adr_o == 32'h4) && (rx_reads >= 1);
            else           hit = bus.m_valid;
        end
        chk("reset_trigger_seen", hit, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_mid_stb", bus.wb_stb_o, 1'b0);
        chk("rst_mid_valid", bus.m_valid, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        clear_model();
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        logic [23:0] ra;
        logic [7:0]  rd;
        rst_i = 1'b1; start = 1'b0; addr = '0; len = '0; clk_div = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_stb", bus.wb_stb_o, 1'b0);
        chk("rst_we", bus.wb_we_o, 1'b0);
        chk("rst_adr", bus.wb_adr_o, 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        chk("rst_sel", bus.wb_sel_o, 4'hF);
        chk("rst_valid", bus.m_valid, 1'b0);
        chk("rst_data", bus.m_data, 8'h00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            preset_rx_q.push_back(8'hA0); preset_rx_q.push_back(8'hA1);
            preset_rx_q.push_back(8'hA2); preset_rx_q.push_back(8'hA3);
            if (HDR == 5) preset_rx_q.push_back(8'hA4);
            preset_rx_q.push_back(8'h5A); preset_rx_q.push_back(8'hC3);
            run_read(24'h123456, 2, 8'h04, 0, k[0]);
        end

        run_read(24'hABCDEF, 0, 8'h02, 0, 0);
        run_read(24'h000100, 1, 8'h01, 3, 0);

        reset_mid(0);
        run_read(24'h0F0E0D, 1, 8'h05, -1, 0);
        rand_ready = 1;
        reset_mid(1);
        run_read(24'h55AA33, 1, 8'h07, -1, 0);

        run_read(24'h000010, 1, 8'h10, -1, 0);
        run_read(24'hFFFFFE, (1 << LW) - 1, 8'hFF, -1, 0);

        for (int t = 0; t < 12; t++) begin
            ra = 24'($urandom());
            rd = 8'($urandom());
            run_read(ra, $urandom_range(0, 5), rd, -1, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_flash_rd_seq.md
Name: spi_flash_rd_seq

Overview:
- Wishbone master that sits directly upstream of the team's Wishbone SPI controller and drives it through that controller's register map.
- On a start pulse it configures the controller and sends a serial-flash READ: command byte, 24-bit address, then N dummy bytes.
- It returns the N received bytes on a valid/ready byte stream.
- Purpose: lets a DMA or boot loader pull flash contents without CPU register polling.

Parameters:
- LW, 16, width of the byte-count input len.
- CDW, 8, width of the SPI clock divider; must match the controller's divider width.

Ports:
- clk  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- addr  in  24  flash byte address, captured on start
- len  in  LW  number of data bytes to read, captured on start
- clk_div  in  CDW  SPI divider value, written to CFG
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the read completes
- m_data  out  8  stream byte
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_sel_o  out  4  always 4'hF
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values: all outputs 0 except wb_sel_o = 4'hF. FSM goes to IDLE; internal counters cleared.
- Reset mid-operation: takes effect at once; cyc/stb drop asynchronously and any buffered byte is lost.
- Target offsets: RXDATA 0x00, TXDATA 0x04, CFG 0x08, CTRL 0x0C, RX_FIFO_LEVEL 0xFE00. Upper 16 address bits are 0.
- Wishbone access rules:
  - cyc and stb are asserted together with adr, we and dat held stable until the first cycle wb_ack_i = 1.
  - On that cycle the access completes; read data is captured from wb_dat_i.
  - cyc and stb are low for at least one cycle between accesses, because the slave acks any cycle in which strobe was high.
  - No timeout.
- FSM states:
  - IDLE: start=1 captures addr, len, clk_div.
    - len == 0: done_o pulses in the following cycle, busy_o stays 0, no Wishbone traffic.
    - Otherwise go to CFG.
  - CFG: write CFG = {clk_div, CPHA=0, CPOL=0} (divider in bits [CDW+1:2]).
  - FLUSH: write CTRL = 0x7 (rx_en, rx_flush, tx_flush).
  - EN: write CTRL = 0x1 (flush bits released).
  - TX: write TXDATA with the next byte in the sequence 0x03, addr[23:16], addr[15:8], addr[7:0], then 0x00 per data byte.
  - POLL: read RX_FIFO_LEVEL; repeat (with the idle gap) until the value is non-zero.
  - RX: read RXDATA and take wb_dat_i[7:0].
    - Header bytes (index < 4) are discarded; go to TX.
    - Data bytes are loaded into m_data with m_valid = 1; go to OUT.
  - OUT: hold until m_valid & m_ready.
    - If remaining count is still non-zero, go to TX.
    - Otherwise go to FIN.
    - No new TX byte is issued while a stream byte is pending (one byte in flight).
  - FIN: write CTRL = 0x0, pulse done_o, return to IDLE; busy_o falls in the same cycle as done_o.
- Counters:
  - Byte index is 3 bits, saturating after the header.
  - Remaining count is LW bits, decremented on each stream handshake.
  - len at its maximum value (all ones) is legal.
- start while busy is ignored.
- m_data is stable while m_valid is high and not yet accepted.

Optional Feature:
- Macro: SPI_FLASH_RD_FAST_EN.
- Defined: command byte is 0x0B (FAST READ) and one extra 0x00 dummy byte follows the address; the header is 5 bytes and the first 5 RX bytes are discarded.
- Undefined: command 0x03 with a 4-byte header, as above.

Test Plan:
- start, addr = 0x123456, len = 2, slave model returns RX bytes A0 A1 A2 A3 5A C3 -> TXDATA writes 03 12 34 56 00 00; stream carries 5A then C3; done_o pulses once; final CTRL write is 0x0.
- Same read with m_ready held low for 10 cycles after the first byte -> m_valid/m_data = 5A held stable; no TXDATA write occurs until the handshake.
- start with len = 0 -> done_o one cycle later; no cyc_o assertion; busy_o never high.
- RX_FIFO_LEVEL model returns 0 three times before returning 1 -> exactly 4 level reads, each separated by cyc_o low ≥1 cycle; then a single RXDATA read.
- rst_i asserted mid-TX while cyc_o = 1 -> cyc_o/stb_o/m_valid go to 0 immediately; after release, a new start with len = 1 completes normally.
- With SPI_FLASH_RD_FAST_EN, addr = 0x000010, len = 1 -> TXDATA writes 0B 00 00 10 00 00; only the 6th RX byte is streamed.
